// File: rtl/tlul_dw_downsizer.sv
// tlul_dw_downsizer: carries one wide TL-UL host transaction at a time onto a
// narrower TL-UL device port. A wide access is split into device-width beats
// walked lane by lane, and the device responses are gathered back into the
// matching lanes of a single host response.
module tlul_dw_downsizer #(
    parameter int HDW = 64,
    parameter int DDW = 32,
    parameter int AW  = 32,
    parameter int AIW = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    // host A channel
    input  logic                                h_a_valid,
    output logic                                h_a_ready,
    input  logic [2:0]                          h_a_opcode,
    input  logic [$clog2($clog2(HDW/8)+1)-1:0]  h_a_size,
    input  logic [AIW-1:0]                      h_a_source,
    input  logic [AW-1:0]                       h_a_address,
    input  logic [HDW/8-1:0]                    h_a_mask,
    input  logic [HDW-1:0]                      h_a_data,
    // host D channel
    output logic                                h_d_valid,
    input  logic                                h_d_ready,
    output logic [2:0]                          h_d_opcode,
    output logic [$clog2($clog2(HDW/8)+1)-1:0]  h_d_size,
    output logic [AIW-1:0]                      h_d_source,
    output logic [HDW-1:0]                      h_d_data,
    output logic                                h_d_error,
    // device A channel
    output logic                                d_a_valid,
    input  logic                                d_a_ready,
    output logic [2:0]                          d_a_opcode,
    output logic [$clog2($clog2(DDW/8)+1)-1:0]  d_a_size,
    output logic [AIW-1:0]                      d_a_source,
    output logic [AW-1:0]                       d_a_address,
    output logic [DDW/8-1:0]                    d_a_mask,
    output logic [DDW-1:0]                      d_a_data,
    // device D channel
    input  logic                                d_d_valid,
    output logic                                d_d_ready,
    input  logic [2:0]                          d_d_opcode,
    input  logic [DDW-1:0]                      d_d_data,
    input  logic                                d_d_error
);

    localparam int HBYTES = HDW / 8;
    localparam int DBYTES = DDW / 8;
    localparam int R      = HDW / DDW;
    localparam int HOFF   = $clog2(HBYTES);
    localparam int DOFF   = $clog2(DBYTES);
    localparam int LW     = HOFF - DOFF;
    localparam int LANEW  = (LW > 0) ? LW : 1;
    localparam int HSZW   = $clog2(HOFF + 1);
    localparam int DSZW   = $clog2(DOFF + 1);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e             state_q;
    logic               h_a_ready_q;
    logic               d_a_valid_q;
    logic               d_d_ready_q;
    logic               h_d_valid_q;

    logic [2:0]         op_q;
    logic [HSZW-1:0]    size_q;
    logic [AIW-1:0]     src_q;
    logic [AW-1:0]      addr_q;
    logic [HBYTES-1:0]  mask_q;
    logic [HDW-1:0]     data_q;
    logic               single_q;

    logic [R-1:0]       pend_q;
    logic [LANEW-1:0]   lane_q;
    logic [HDW-1:0]     acc_q;
    logic               err_q;

    logic [R-1:0]       pend_d;
    logic [LANEW-1:0]   lane0_d;
    logic               single_d;

    logic [AW-1:0]      beat_addr;
    logic [DSZW-1:0]    beat_size;
    logic [DBYTES-1:0]  beat_mask;
    logic [DDW-1:0]     beat_data;

    logic               unused_d_d_opcode;
    assign unused_d_d_opcode = ^d_d_opcode;

    function automatic logic is_put(input logic [2:0] op);
        is_put = (op == OP_PUT_FULL) || (op == OP_PUT_PART);
    endfunction

    // Lowest lane still waiting to be issued.
    function automatic logic [LANEW-1:0] first_lane(input logic [R-1:0] p);
        first_lane = '0;
        for (int i = R - 1; i >= 0; i--) begin
            if (p[i]) first_lane = LANEW'(i);
        end
    endfunction

    function automatic logic [R-1:0] lane_onehot(input logic [LANEW-1:0] lane);
        lane_onehot = '0;
        for (int i = 0; i < R; i++) begin
            if (LANEW'(i) == lane) lane_onehot[i] = 1'b1;
        end
    endfunction

    // Work out which device lanes the incoming host request will need.
    // Put lanes with no enabled byte are dropped, but at least one beat
    // (the last lane of the span) always goes out so the device acks it.
    always_comb begin : p_plan
        int nlog;
        int n;
        int l0;
        nlog = 0;
        if (int'(h_a_size) > DOFF) nlog = int'(h_a_size) - DOFF;
        if (nlog > LW) nlog = LW;
        n  = 1 << nlog;
        l0 = int'(h_a_address >> DOFF) & (R - 1) & ~(n - 1);
        pend_d = '0;
        for (int i = 0; i < R; i++) begin
            if ((i >= l0) && (i < l0 + n) &&
                (!is_put(h_a_opcode) || (h_a_mask[i*DBYTES +: DBYTES] != '0))) begin
                pend_d[i] = 1'b1;
            end
        end
        if (pend_d == '0) begin
            for (int i = 0; i < R; i++) begin
                if (i == l0 + n - 1) pend_d[i] = 1'b1;
            end
        end
        single_d = (nlog == 0);
        lane0_d  = first_lane(pend_d);
    end

    // Latch the host request fields for the duration of the transaction.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && h_a_valid) begin
            op_q     <= h_a_opcode;
            size_q   <= h_a_size;
            src_q    <= h_a_source;
            addr_q   <= h_a_address;
            mask_q   <= h_a_mask;
            data_q   <= h_a_data;
            single_q <= single_d;
        end
    end

    // Transaction sequencer: accept, issue each lane, collect, respond.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            h_a_ready_q <= 1'b1;
            d_a_valid_q <= 1'b0;
            d_d_ready_q <= 1'b0;
            h_d_valid_q <= 1'b0;
            pend_q      <= '0;
            lane_q      <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (h_a_valid) begin
                        acc_q       <= '0;
                        err_q       <= 1'b0;
                        pend_q      <= pend_d;
                        lane_q      <= lane0_d;
                        h_a_ready_q <= 1'b0;
                        d_a_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (d_a_ready) begin
                        pend_q      <= pend_q & ~lane_onehot(lane_q);
                        d_a_valid_q <= 1'b0;
                        d_d_ready_q <= 1'b1;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (d_d_valid) begin
                        for (int i = 0; i < R; i++) begin
                            if (LANEW'(i) == lane_q) acc_q[i*DDW +: DDW] <= d_d_data;
                        end
                        err_q       <= err_q | d_d_error;
                        d_d_ready_q <= 1'b0;
                        if (pend_q != '0) begin
                            lane_q      <= first_lane(pend_q);
                            d_a_valid_q <= 1'b1;
                            state_q     <= ISSUE;
                        end else begin
                            h_d_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (h_d_ready) begin
                        h_d_valid_q <= 1'b0;
                        h_a_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    h_a_ready_q <= 1'b1;
                    d_a_valid_q <= 1'b0;
                    d_d_ready_q <= 1'b0;
                    h_d_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Select the current lane out of the captured wide mask and data.
    always_comb begin
        beat_mask = '0;
        beat_data = '0;
        for (int i = 0; i < R; i++) begin
            if (LANEW'(i) == lane_q) begin
                beat_mask = mask_q[i*DBYTES +: DBYTES];
                beat_data = data_q[i*DDW +: DDW];
            end
        end
    end

    // Multi-beat requests are lane aligned, a single narrow beat keeps its
    // byte offset so the device sees the original sub-word address.
    assign beat_addr = (addr_q & ~AW'(HBYTES - 1)) | (AW'(lane_q) << DOFF) |
                       (single_q ? (addr_q & AW'(DBYTES - 1)) : '0);
    assign beat_size = (int'(size_q) > DOFF) ? DSZW'(DOFF) : DSZW'(size_q);

    assign h_a_ready   = h_a_ready_q;
    assign d_d_ready   = d_d_ready_q;

    assign d_a_valid   = d_a_valid_q;
    assign d_a_opcode  = d_a_valid_q ? op_q      : 3'd0;
    assign d_a_size    = d_a_valid_q ? beat_size : '0;
    assign d_a_source  = d_a_valid_q ? src_q     : '0;
    assign d_a_address = d_a_valid_q ? beat_addr : '0;
    assign d_a_mask    = d_a_valid_q ? beat_mask : '0;
    assign d_a_data    = d_a_valid_q ? beat_data : '0;

    assign h_d_valid   = h_d_valid_q;
    assign h_d_opcode  = !h_d_valid_q ? 3'd0 : ((op_q == OP_GET) ? OP_ACK_DATA : OP_ACK);
    assign h_d_size    = h_d_valid_q ? size_q : '0;
    assign h_d_source  = h_d_valid_q ? src_q  : '0;
    assign h_d_data    = h_d_valid_q ? acc_q  : '0;
    assign h_d_error   = h_d_valid_q & err_q;

endmodule

// File: tb/tb_tlul_dw_downsizer.sv
// Bench for tlul_dw_downsizer: directed scenarios plus random transactions,
// checked against a byte-address model of how a wide access splits up.
`timescale 1ns/1ps
module tb_tlul_dw_downsizer;
    localparam int HDW = 64;
    localparam int DDW = 32;
    localparam int AW  = 32;
    localparam int AIW = 8;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            h_a_valid, h_a_ready;
    logic [2:0]      h_a_opcode;
    logic [1:0]      h_a_size;
    logic [AIW-1:0]  h_a_source;
    logic [AW-1:0]   h_a_address;
    logic [7:0]      h_a_mask;
    logic [HDW-1:0]  h_a_data;
    logic            h_d_valid, h_d_ready;
    logic [2:0]      h_d_opcode;
    logic [1:0]      h_d_size;
    logic [AIW-1:0]  h_d_source;
    logic [HDW-1:0]  h_d_data;
    logic            h_d_error;
    logic            d_a_valid, d_a_ready;
    logic [2:0]      d_a_opcode;
    logic [1:0]      d_a_size;
    logic [AIW-1:0]  d_a_source;
    logic [AW-1:0]   d_a_address;
    logic [3:0]      d_a_mask;
    logic [DDW-1:0]  d_a_data;
    logic            d_d_valid, d_d_ready;
    logic [2:0]      d_d_opcode;
    logic [DDW-1:0]  d_d_data;
    logic            d_d_error;

    always #5 clk = ~clk;

    tlul_dw_downsizer #(.HDW(HDW), .DDW(DDW), .AW(AW), .AIW(AIW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .h_a_valid(h_a_valid), .h_a_ready(h_a_ready), .h_a_opcode(h_a_opcode),
        .h_a_size(h_a_size), .h_a_source(h_a_source), .h_a_address(h_a_address),
        .h_a_mask(h_a_mask), .h_a_data(h_a_data),
        .h_d_valid(h_d_valid), .h_d_ready(h_d_ready), .h_d_opcode(h_d_opcode),
        .h_d_size(h_d_size), .h_d_source(h_d_source), .h_d_data(h_d_data),
        .h_d_error(h_d_error),
        .d_a_valid(d_a_valid), .d_a_ready(d_a_ready), .d_a_opcode(d_a_opcode),
        .d_a_size(d_a_size), .d_a_source(d_a_source), .d_a_address(d_a_address),
        .d_a_mask(d_a_mask), .d_a_data(d_a_data),
        .d_d_valid(d_d_valid), .d_d_ready(d_d_ready), .d_d_opcode(d_d_opcode),
        .d_d_data(d_d_data), .d_d_error(d_d_error)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  sz;
        logic [3:0]  mask;
        logic [31:0] data;
    } beat_t;

    beat_t        exp_q[$];
    logic [31:0]  dd_data_q[$];
    logic         dd_err_q[$];
    int           a_hold, d_hold, hd_hold;
    int           checks = 0;
    int           failures = 0;
    int           beats_seen;
    logic [31:0]  last_da_addr;
    logic [1:0]   last_da_size;
    logic [3:0]   last_da_mask;
    logic [31:0]  last_da_data;
    logic [63:0]  last_hd_data;
    logic         last_hd_err;
    logic [2:0]   last_hd_op;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expected device beats: split the byte range [aligned addr, +2^size) into
    // 4-byte words, dropping Put words with no enabled byte unless nothing
    // would otherwise be sent.
    task automatic plan_beats(input logic [2:0] op, input logic [1:0] size,
                              input logic [31:0] addr, input logic [7:0] mask,
                              input logic [63:0] data);
        int          bytes, nbeats, lane;
        logic [31:0] a;
        logic [3:0]  m;
        beat_t       bt;
        logic        put;
        put = (op == 3'd0) || (op == 3'd1);
        exp_q.delete();
        bytes = 1 << size;
        if (bytes <= 4) begin
            lane    = int'(addr % 8) / 4;
            bt.addr = addr;
            bt.sz   = size;
            bt.mask = 4'(mask >> (4 * lane));
            bt.data = 32'(data >> (32 * lane));
            exp_q.push_back(bt);
        end else begin
            nbeats = bytes / 4;
            for (int k = 0; k < nbeats; k++) begin
                a    = (addr & ~(32'(bytes) - 32'd1)) + 32'(4 * k);
                lane = int'(a % 8) / 4;
                m    = 4'(mask >> (4 * lane));
                if (put && m == 4'h0 && !(k == nbeats - 1 && exp_q.size() == 0)) continue;
                bt.addr = a;
                bt.sz   = 2'd2;
                bt.mask = m;
                bt.data = 32'(data >> (32 * lane));
                exp_q.push_back(bt);
            end
        end
    endtask

    task automatic check_beat(input beat_t b, input logic [2:0] op, input logic [7:0] src);
        check_eq("da_opcode", d_a_opcode, op);
        check_eq("da_source", d_a_source, src);
        check_eq("da_address", d_a_address, b.addr);
        check_eq("da_size", d_a_size, b.sz);
        check_eq("da_mask", d_a_mask, b.mask);
        check_eq("da_data", d_a_data, b.data);
        check_eq("ha_ready_busy", h_a_ready, 1'b0);
    endtask

    task automatic do_txn(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                          input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data);
        logic [63:0] exp_data;
        logic        exp_err;
        logic [31:0] rdata;
        logic        rerr;
        logic [2:0]  exp_op;
        int          n, dly, nb;
        plan_beats(op, size, addr, mask, data);
        exp_data   = '0;
        exp_err    = 1'b0;
        exp_op     = (op == 3'd4) ? 3'd1 : 3'd0;
        beats_seen = 0;
        h_a_valid = 1'b1; h_a_opcode = op; h_a_size = size; h_a_source = src;
        h_a_address = addr; h_a_mask = mask; h_a_data = data;
        n = 0;
        while (!h_a_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!h_a_ready) begin check_eq("ha_ready_timeout", 0, 1); h_a_valid = 1'b0; return; end
        @(posedge clk); #1;
        h_a_valid = 1'b0; h_a_data = {$urandom, $urandom}; h_a_address = $urandom;
        h_a_mask = 8'($urandom); h_a_opcode = 3'($urandom); h_a_source = 8'($urandom);
        nb = exp_q.size();
        for (int b = 0; b < nb; b++) begin
            n = 0;
            while (!d_a_valid && n < 50) begin
                check_eq("hd_early", h_d_valid, 1'b0);
                @(posedge clk); #1; n++;
            end
            if (!d_a_valid) begin check_eq("da_valid_timeout", 0, 1); return; end
            dly = (a_hold >= 0) ? a_hold : $urandom_range(0, 3);
            for (int k = 0; k < dly; k++) begin
                check_beat(exp_q[b], op, src);
                check_eq("dd_ready_issue", d_d_ready, 1'b0);
                d_d_valid = 1'b1; d_d_data = $urandom; d_d_error = 1'b1;
                @(posedge clk); #1;
            end
            d_d_valid = 1'b0; d_d_error = 1'b0;
            check_beat(exp_q[b], op, src);
            last_da_addr = d_a_address; last_da_size = d_a_size;
            last_da_mask = d_a_mask;    last_da_data = d_a_data;
            d_a_ready = 1'b1;
            @(posedge clk); #1;
            d_a_ready = 1'b0;
            beats_seen++;
            check_eq("dd_ready_wait", d_d_ready, 1'b1);
            check_eq("da_valid_wait", d_a_valid, 1'b0);
            dly = (d_hold >= 0) ? d_hold : $urandom_range(0, 3);
            for (int k = 0; k < dly; k++) begin @(posedge clk); #1; end
            rdata = (dd_data_q.size() > 0) ? dd_data_q.pop_front() : $urandom;
            rerr  = (dd_err_q.size() > 0)  ? dd_err_q.pop_front()  : ($urandom_range(0, 7) == 0);
            d_d_valid = 1'b1; d_d_data = rdata; d_d_error = rerr;
            @(posedge clk); #1;
            d_d_valid = 1'b0; d_d_data = $urandom; d_d_error = 1'b0;
            check_eq("dd_ready_off", d_d_ready, 1'b0);
            exp_data = exp_data | (64'(rdata) << (32 * (int'(exp_q[b].addr % 8) / 4)));
            exp_err  = exp_err | rerr;
        end
        n = 0;
        while (!h_d_valid && n < 50) begin
            check_eq("da_extra_beat", d_a_valid, 1'b0);
            @(posedge clk); #1; n++;
        end
        if (!h_d_valid) begin check_eq("hd_valid_timeout", 0, 1); return; end
        dly = (hd_hold >= 0) ? hd_hold : $urandom_range(0, 2);
        for (int k = 0; k <= dly; k++) begin
            check_eq("hd_opcode", h_d_opcode, exp_op);
            check_eq("hd_size", h_d_size, size);
            check_eq("hd_source", h_d_source, src);
            check_eq("hd_data", h_d_data, exp_data);
            check_eq("hd_error", h_d_error, exp_err);
            check_eq("ha_ready_resp", h_a_ready, 1'b0);
            check_eq("da_valid_resp", d_a_valid, 1'b0);
            if (k < dly) begin @(posedge clk); #1; end
        end
        last_hd_data = h_d_data; last_hd_err = h_d_error; last_hd_op = h_d_opcode;
        h_d_ready = 1'b1;
        @(posedge clk); #1;
        h_d_ready = 1'b0;
        check_eq("hd_valid_once", h_d_valid, 1'b0);
        check_eq("ha_ready_back", h_a_ready, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [7:0]  mask;
        int          n;
        h_a_valid = 0; h_a_opcode = 0; h_a_size = 0; h_a_source = 0; h_a_address = 0;
        h_a_mask = 0; h_a_data = 0; h_d_ready = 0; d_a_ready = 0; d_d_valid = 0;
        d_d_opcode = 0; d_d_data = 0; d_d_error = 0;
        a_hold = -1; d_hold = -1; hd_hold = -1;
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        check_eq("rst_ha_ready", h_a_ready, 1'b1);
        check_eq("rst_hd_valid", h_d_valid, 1'b0);
        check_eq("rst_da_valid", d_a_valid, 1'b0);
        check_eq("rst_dd_ready", d_d_ready, 1'b0);
        check_eq("rst_da_address", d_a_address, 0);
        check_eq("rst_da_data", d_a_data, 0);
        check_eq("rst_hd_data", h_d_data, 0);
        check_eq("rst_hd_error", h_d_error, 0);

        // Wide Get split into two device reads.
        dd_data_q = '{32'h11111111, 32'h22222222}; dd_err_q = '{1'b0, 1'b0};
        do_txn(3'd4, 2'd3, 8'h5A, 32'h100, 8'hFF, 64'h0);
        check_eq("get64_data", last_hd_data, 64'h2222222211111111);
        check_eq("get64_opcode", last_hd_op, 3'd1);
        check_eq("get64_beats", beats_seen, 2);

        // PutPartial touching only the upper lane.
        do_txn(3'd1, 2'd3, 8'h21, 32'h208, 8'hF0, 64'hAABBCCDD_00000000);
        check_eq("putpart_beats", beats_seen, 1);
        check_eq("putpart_addr", last_da_addr, 32'h20C);
        check_eq("putpart_mask", last_da_mask, 4'hF);
        check_eq("putpart_data", last_da_data, 32'hAABBCCDD);
        check_eq("putpart_opcode", last_hd_op, 3'd0);

        // Error on the second beat folds into the host response.
        dd_err_q = '{1'b0, 1'b1};
        do_txn(3'd4, 2'd3, 8'h03, 32'h180, 8'hFF, 64'h0);
        check_eq("err_second_beat", last_hd_err, 1'b1);

        // Narrow Get in the upper lane.
        dd_data_q = '{32'h1234ABCD}; dd_err_q = '{1'b0};
        do_txn(3'd4, 2'd1, 8'h44, 32'h106, 8'hFF, 64'h0);
        check_eq("get16_beats", beats_seen, 1);
        check_eq("get16_addr", last_da_addr, 32'h106);
        check_eq("get16_size", last_da_size, 2'd1);
        check_eq("get16_data", last_hd_data, 64'h1234ABCD_00000000);

        // Put with no enabled bytes still sends its last word.
        do_txn(3'd0, 2'd3, 8'h09, 32'h300, 8'h00, 64'h0123456789ABCDEF);
        check_eq("putzero_beats", beats_seen, 1);
        check_eq("putzero_addr", last_da_addr, 32'h304);

        // Back-pressure on both sides.
        a_hold = 5; hd_hold = 3;
        do_txn(3'd4, 2'd3, 8'h77, 32'h440, 8'hFF, 64'h0);
        a_hold = -1; hd_hold = -1;

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0: op = 3'd0;
                1: op = 3'd1;
                default: op = 3'd4;
            endcase
            size = 2'($urandom_range(0, 3));
            addr = $urandom;
            addr = addr & ~((32'd1 << size) - 32'd1);
            case ($urandom_range(0, 4))
                0: mask = 8'h0F;
                1: mask = 8'hF0;
                2: mask = 8'h00;
                3: mask = 8'hFF;
                default: mask = 8'($urandom);
            endcase
            do_txn(op, size, 8'($urandom), addr, mask, {$urandom, $urandom});
        end

        // Reset while waiting on the device abandons the transaction.
        h_a_valid = 1'b1; h_a_opcode = 3'd4; h_a_size = 2'd3; h_a_address = 32'h500;
        h_a_mask = 8'hFF; h_a_source = 8'h66;
        n = 0;
        while (!h_a_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        h_a_valid = 1'b0;
        n = 0;
        while (!d_a_valid && n < 50) begin @(posedge clk); #1; n++; end
        check_eq("rstwait_da_valid", d_a_valid, 1'b1);
        d_a_ready = 1'b1;
        @(posedge clk); #1;
        d_a_ready = 1'b0;
        check_eq("rstwait_in_wait", d_d_ready, 1'b1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check_eq("rstwait_ha_ready", h_a_ready, 1'b1);
        check_eq("rstwait_dd_ready", d_d_ready, 1'b0);
        check_eq("rstwait_hd_valid", h_d_valid, 1'b0);
        check_eq("rstwait_da_valid_off", d_a_valid, 1'b0);
        d_d_valid = 1'b1; d_d_data = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check_eq("rstwait_no_resp", h_d_valid, 1'b0);
            check_eq("rstwait_idle", h_a_ready, 1'b1);
        end
        d_d_valid = 1'b0;

        dd_data_q = '{32'hCAFEF00D, 32'h0BADC0DE}; dd_err_q = '{1'b0, 1'b0};
        do_txn(3'd4, 2'd3, 8'h12, 32'h508, 8'hFF, 64'h0);
        check_eq("after_rst_data", last_hd_data, 64'h0BADC0DE_CAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
